pipeif_fetch: RTL and testbench

Instruction-fetch stage plus IF/ID pipeline register for the five-stage pipelined CPU. It sits directly upstream of `pipeidcu`. It drives a ready-handshaked instruction memory and presents `dpc4`/`dinst`/`dvalid` to the ID stage. It consumes the ID-stage `pcsource`, branch/jump targets and `load_depen` stall, and honours one architectural delay slot (no flush).

---
 rtl/pipeif_fetch.sv | 151 +++++++++++++++
 tb/tb_pipeif_fetch.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeif_fetch.sv
// pipeif_fetch: instruction-fetch stage and IF/ID register.
// Fetches from a ready-handshaked imem, holds one completed
// fetch across an ID stall, and honours one delay slot.
// Ports: clock/resetn; pcsource, bpc, ra, jpc, load_depen
// from ID; imem_req/addr/rdata/ready; dpc4/dinst/dvalid to
// ID; pc (debug).

package pipeif_pkg;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] inst;
        logic        valid;
    } if_id_t;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_FETCH,
        ST_HOLD
    } fetch_st_e;

endpackage

module pipeif_fetch
    import pipeif_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] ra,
    input  logic [31:0] jpc,
    input  logic        load_depen,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] dpc4,
    output logic [31:0] dinst,
    output logic        dvalid,
    output logic [31:0] pc
);

    fetch_st_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    if_id_t      ifid_q, ifid_d;
    logic        pend_q, pend_d;
    logic [31:0] rpc_q, rpc_d;
    logic [31:0] hold_q, hold_d;

    logic        ifid_en;
    logic        id_acc;
    logic        redir;
    logic [31:0] tgt;
    logic [31:0] pc4;
    logic [31:0] next_pc;
    logic        deliver;
    logic [31:0] inst_sel;

    always_comb begin
        ifid_en  = ~ifid_q.valid | ~load_depen;
        id_acc   = ifid_q.valid & ~load_depen;
        redir    = id_acc & (pcsource != 2'b00);
        pc4      = pc_q + 32'd4;
        next_pc  = pend_q ? rpc_q : pc4;

        unique case (pcsource)
            2'b10:   tgt = ra;
            2'b11:   tgt = jpc;
            default: tgt = bpc;
        endcase

        state_d  = state_q;
        pc_d     = pc_q;
        ifid_d   = ifid_q;
        pend_d   = pend_q;
        rpc_d    = rpc_q;
        hold_d   = hold_q;
        deliver  = 1'b0;
        inst_sel = imem_rdata;

        unique case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ready) begin
                    if (ifid_en) begin
                        deliver = 1'b1;
                    end else begin
                        hold_d  = imem_rdata;
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (ifid_en) begin
                    deliver  = 1'b1;
                    inst_sel = hold_q;
                    state_d  = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase

        // A redirect seen in the same cycle the delay slot
        // lands can steer pc directly; otherwise it waits.
        if (deliver) begin
            ifid_d = '{pc4: pc4, inst: inst_sel, valid: 1'b1};
            pend_d = 1'b0;
            pc_d   = redir ? tgt : next_pc;
        end else if (ifid_en) begin
            ifid_d.valid = 1'b0;
            if (redir) begin
                pend_d = 1'b1;
                rpc_d  = tgt;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            ifid_q  <= '0;
            pend_q  <= 1'b0;
            rpc_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ifid_q  <= ifid_d;
            pend_q  <= pend_d;
            rpc_q   <= rpc_d;
            hold_q  <= hold_d;
        end
    end

    // Request is decoded from state so reset drops it at once.
    assign imem_req  = (state_q == ST_FETCH);
    assign imem_addr = pc_q;
    assign dpc4      = ifid_q.pc4;
    assign dinst     = ifid_q.inst;
    assign dvalid    = ifid_q.valid;
    assign pc        = pc_q;

endmodule

// File: tb/tb_pipeif_fetch.sv
// tb_pipeif_fetch: directed bench for pipeif_fetch with a
// latency-configurable imem model and an address scoreboard.

`define CHK(tag, obs, exp) \
    begin \
        n_vec++; \
        assert ((obs) === (exp)) else begin \
            n_err++; \
            $error("FAIL %s: observed %0h, expected %0h", \
                   tag, (obs), (exp)); \
        end \
    end

module tb_pipeif_fetch;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [1:0]  pcsource = 2'b00;
    logic [31:0] bpc = '0;
    logic [31:0] ra = '0;
    logic [31:0] jpc = '0;
    logic        load_depen = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        imem_ready = 1'b0;
    logic [31:0] dpc4;
    logic [31:0] dinst;
    logic        dvalid;
    logic [31:0] pc;

    always #5 clock = ~clock;

    pipeif_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .pcsource   (pcsource),
        .bpc        (bpc),
        .ra         (ra),
        .jpc        (jpc),
        .load_depen (load_depen),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ready (imem_ready),
        .dpc4       (dpc4),
        .dinst      (dinst),
        .dvalid     (dvalid),
        .pc         (pc)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] exp_q[$];

    int          lat = 1;
    int          wcnt = 0;
    logic        prev_req = 1'b0;
    logic        prev_rdy = 1'b0;
    logic        prev_dv = 1'b0;
    logic [31:0] prev_addr = '0;

    logic [31:0] br_at = '1;
    logic [1:0]  br_src = 2'b00;
    bit          br_done = 1'b0;
    logic [31:0] stall_at = '1;
    int          stall_left = 0;
    bit          stall_done = 1'b0;
    logic [31:0] chk_at = '1;
    logic [31:0] chk_addr = '0;

    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'h0000_000C) return 32'h8C22_0000;
        return {a[15:0] ^ 16'hA5C3, a[15:0]};
    endfunction

    task automatic tick();
        logic [31:0] e;
        @(posedge clock);
        #1;
        if (!imem_req || prev_rdy || !prev_req) wcnt = 0;
        else wcnt++;
        if (imem_req && prev_req && !prev_rdy)
            `CHK("addr_stable", imem_addr, prev_addr)
        imem_ready = imem_req && (wcnt >= lat - 1);
        imem_rdata = imem_ready ? mem(imem_addr) : 32'hDEAD_BEEF;

        if (!stall_done && stall_left == 0 && dvalid &&
            dpc4 == stall_at) begin
            stall_left = 3;
            stall_done = 1'b1;
        end
        load_depen = (stall_left > 0);
        if (stall_left > 0) stall_left--;
        if (load_depen && stall_left <= 1) begin
            `CHK("hold_req", imem_req, 1'b0)
            `CHK("hold_pc", pc, 32'h10)
            `CHK("hold_dpc4", dpc4, 32'h10)
            `CHK("hold_dinst", dinst, 32'h8C22_0000)
            `CHK("hold_dvalid", dvalid, 1'b1)
        end

        pcsource = 2'b00;
        if (!br_done && dvalid && !load_depen && dpc4 == br_at) begin
            pcsource = br_src;
            br_done  = 1'b1;
        end

        if (dvalid && dpc4 == chk_at)
            `CHK("redir_addr", imem_addr, chk_addr)
        if (lat == 1 && prev_dv)
            `CHK("steady_valid", dvalid, 1'b1)
        if (lat == 2)
            `CHK("alternate", prev_dv & dvalid, 1'b0)

        if (dvalid && !load_depen) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $error("FAIL extra_inst: observed dpc4 %0h, expected none",
                       dpc4);
            end else begin
                e = exp_q.pop_front();
                `CHK("dpc4", dpc4, 32'(e + 32'd4))
                `CHK("dinst", dinst, mem(e))
            end
        end

        prev_req  = imem_req;
        prev_rdy  = imem_ready;
        prev_addr = imem_addr;
        prev_dv   = dvalid;
    endtask

    task automatic drain(input int budget);
        int b;
        b = budget;
        while (exp_q.size() > 0 && b > 0) begin
            tick();
            b--;
        end
        `CHK("drain_left", exp_q.size(), 0)
    endtask

    task automatic do_reset(input int l);
        #2 resetn = 1'b0;
        #1;
        `CHK("rst_req", imem_req, 1'b0)
        `CHK("rst_dvalid", dvalid, 1'b0)
        `CHK("rst_pc", pc, 32'h0)
        `CHK("rst_dpc4", dpc4, 32'h0)
        `CHK("rst_dinst", dinst, 32'h0)
        exp_q.delete();
        lat        = l;
        wcnt       = 0;
        prev_req   = 1'b0;
        prev_rdy   = 1'b0;
        prev_dv    = 1'b0;
        prev_addr  = '0;
        imem_ready = 1'b0;
        imem_rdata = '0;
        load_depen = 1'b0;
        pcsource   = 2'b00;
        br_at      = '1;
        br_src     = 2'b00;
        br_done    = 1'b0;
        stall_at   = '1;
        stall_left = 0;
        stall_done = 1'b0;
        chk_at     = '1;
        chk_addr   = '0;
        @(negedge clock);
        resetn = 1'b1;
        `CHK("boot_req", imem_req, 1'b0)
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // zero-wait sequential fetch
        do_reset(1);
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
        tick();
        `CHK("first_req", imem_req, 1'b1)
        `CHK("first_addr", imem_addr, 32'h0)
        `CHK("first_dvalid", dvalid, 1'b0)
        drain(40);

        // two-cycle memory
        do_reset(2);
        for (int i = 0; i < 6; i++) exp_q.push_back(32'(i * 4));
        drain(40);

        // three-cycle load-use stall at dpc4 = 0x10
        do_reset(1);
        stall_at = 32'h10;
        for (int i = 0; i < 7; i++) exp_q.push_back(32'(i * 4));
        drain(40);

        // branch with bypass: slot 0x0C then target 0x40
        do_reset(1);
        ra = 32'h0;
        jpc = 32'h0;
        bpc = 32'h40;
        br_at = 32'h0C;
        br_src = 2'b01;
        chk_at = 32'h10;
        chk_addr = 32'h40;
        exp_q = '{32'h0, 32'h4, 32'h8, 32'hC,
                  32'h40, 32'h44, 32'h48};
        drain(40);

        // jump while delay-slot fetch waits: pending redirect
        do_reset(3);
        bpc = 32'h0;
        jpc = 32'h100;
        br_at = 32'h08;
        br_src = 2'b11;
        chk_at = 32'h0C;
        chk_addr = 32'h100;
        exp_q = '{32'h0, 32'h4, 32'h8, 32'h100, 32'h104};
        drain(60);

        // jr to the top of memory: pc wraps to 0
        do_reset(1);
        jpc = 32'h0;
        ra = 32'hFFFF_FFF8;
        br_at = 32'h08;
        br_src = 2'b10;
        exp_q = '{32'h0, 32'h4, 32'h8, 32'hFFFF_FFF8,
                  32'hFFFF_FFFC, 32'h0, 32'h4};
        drain(40);

        // reset while a fetch is waiting
        do_reset(3);
        exp_q.push_back(32'h0);
        drain(20);
        `CHK("pre_rst_dvalid", dvalid, 1'b1)
        `CHK("pre_rst_req", imem_req, 1'b1)
        do_reset(1);
        exp_q = '{32'h0, 32'h4, 32'h8};
        tick();
        `CHK("restart_addr", imem_addr, 32'h0)
        drain(20);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
